// File: rtl/hack_clock_control_if.sv
// hack_clock_control_if: control inputs and clock-enable/status outputs of the Hack run/step clock controller
interface hack_clock_control_if #(
    parameter int CNT_W = 16
);
    logic tick_in;
    logic btn_step;
    logic sw_run;
    logic halt;
    logic cpu_en;
    logic running;
    logic [CNT_W-1:0] cycle_count;
    modport master(output tick_in, btn_step, sw_run, halt, input cpu_en, running, cycle_count);
    modport slave(input tick_in, btn_step, sw_run, halt, output cpu_en, running, cycle_count);
endinterface

// File: rtl/hack_clock_control.sv
// hack_clock_control: turns divider ticks into one-cycle CPU enables in run or single-step mode, counting issued cycles
module hack_clock_control #(
    parameter int DEBOUNCE = 500_000,
    parameter int CNT_W = 16
) (
    input logic clk_in,
    input logic reset,
    hack_clock_control_if.slave bus
);
    localparam int DW = DEBOUNCE > 1 ? $clog2(DEBOUNCE) : 1;
    typedef enum logic [1:0] {IDLE, RUN, STEP_WAIT} state_t;
    state_t state;
    logic [1:0] s0, s1, db;  // bit 0 = step button, bit 1 = run switch
    logic [DW-1:0] cnt [2];
    logic tick_q, btn_q, cpu_en, running;
    logic [CNT_W-1:0] count;
    logic tick_rise, step_press, run_db;
    assign tick_rise = bus.tick_in & ~tick_q;
    assign step_press = db[0] & ~btn_q;
    assign run_db = db[1];
    assign bus.cpu_en = cpu_en;
    assign bus.running = running;
    assign bus.cycle_count = count;
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            s0 <= '0;
            s1 <= '0;
            db <= '0;
            cnt <= '{default: '0};
        end else begin
            s0 <= {bus.sw_run, bus.btn_step};
            s1 <= s0;
            for (int i = 0; i < 2; i++) begin
                if (s1[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DW'(DEBOUNCE - 1)) begin
                    db[i] <= s1[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + DW'(1);
                end
            end
        end
    end
    // exits from RUN win over a coincident tick; STEP_WAIT ignores halt and further presses
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cpu_en <= 1'b0;
            running <= 1'b0;
            tick_q <= 1'b0;
            btn_q <= 1'b0;
            count <= '0;
        end else begin
            tick_q <= bus.tick_in;
            btn_q <= db[0];
            count <= cpu_en ? count + CNT_W'(1) : count;
            cpu_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (run_db & ~bus.halt) begin
                        state <= RUN;
                        running <= 1'b1;
                    end else if (step_press) begin
                        state <= STEP_WAIT;
                    end
                end
                RUN: begin
                    if (bus.halt | ~run_db) begin
                        state <= IDLE;
                        running <= 1'b0;
                    end else if (tick_rise) begin
                        cpu_en <= 1'b1;
                    end
                end
                STEP_WAIT: begin
                    if (tick_rise) begin
                        cpu_en <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hack_clock_control.sv
// tb_hack_clock_control: table-driven directed check of run, step, debounce, halt, wrap and reset behaviour
module tb_hack_clock_control;
    typedef struct {
        int n;
        logic tick, btn, sw, halt;
        logic en, run;
        logic [3:0] cnt;
        int p;
    } vec_t;
    logic clk_in = 1'b0;
    logic reset = 1'b1;
    int errors = 0;
    int checks = 0;
    vec_t tbl[$];
    hack_clock_control_if #(.CNT_W(4)) bus();
    hack_clock_control #(.DEBOUNCE(4), .CNT_W(4)) dut (.clk_in(clk_in), .reset(reset), .bus(bus));
    always #5 clk_in = ~clk_in;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    function automatic void v(input int n, input logic tick, btn, sw, halt, en, run, input int cnt, p);
        vec_t r;
        r = '{n, tick, btn, sw, halt, en, run, 4'(cnt), p};
        tbl.push_back(r);
    endfunction
    // hold the inputs for r.n clocks, count pulses seen, then compare the final outputs
    task automatic apply(input vec_t r, input string tag);
        int p;
        p = 0;
        for (int i = 0; i < r.n; i++) begin
            @(negedge clk_in);
            bus.tick_in = r.tick;
            bus.btn_step = r.btn;
            bus.sw_run = r.sw;
            bus.halt = r.halt;
            @(posedge clk_in);
            #1;
            if (bus.cpu_en === 1'b1) p++;
        end
        check($sformatf("%s cpu_en", tag), bus.cpu_en, r.en);
        check($sformatf("%s running", tag), bus.running, r.run);
        check($sformatf("%s cycle_count", tag), bus.cycle_count, r.cnt);
        check($sformatf("%s pulses", tag), p, r.p);
    endtask
    task automatic step(input string tag, input int n, input logic tick, btn, sw, halt, en, run, input int cnt, p);
        vec_t r;
        r = '{n, tick, btn, sw, halt, en, run, 4'(cnt), p};
        apply(r, tag);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        v(6, 0, 0, 1, 0, 0, 0, 0, 0);
        v(1, 0, 0, 1, 0, 0, 1, 0, 0);
        v(1, 1, 0, 1, 0, 1, 1, 0, 1);
        v(9, 1, 0, 1, 0, 0, 1, 1, 0);
        v(10, 0, 0, 1, 0, 0, 1, 1, 0);
        for (int k = 2; k <= 5; k++) begin
            v(10, 1, 0, 1, 0, 0, 1, k, 1);
            v(10, 0, 0, 1, 0, 0, 1, k, 0);
        end
        v(1, 0, 0, 1, 1, 0, 0, 5, 0);
        v(10, 1, 0, 1, 1, 0, 0, 5, 0);
        v(10, 0, 0, 1, 1, 0, 0, 5, 0);
        v(10, 0, 1, 1, 1, 0, 0, 5, 0);
        v(10, 1, 0, 1, 1, 0, 0, 6, 1);
        v(10, 0, 0, 1, 1, 0, 0, 6, 0);
        v(1, 0, 0, 1, 0, 0, 1, 6, 0);
        v(1, 1, 0, 1, 1, 0, 0, 6, 0);
        v(9, 1, 0, 1, 0, 0, 1, 6, 0);
        v(10, 0, 0, 1, 0, 0, 1, 6, 0);
        for (int k = 1; k <= 11; k++) begin
            v(10, 1, 0, 1, 0, 0, 1, (6 + k) % 16, 1);
            v(10, 0, 0, 1, 0, 0, 1, (6 + k) % 16, 0);
        end
        v(6, 0, 0, 0, 0, 0, 1, 1, 0);
        v(1, 0, 0, 0, 0, 0, 0, 1, 0);
        v(10, 0, 1, 0, 0, 0, 0, 1, 0);
        v(10, 0, 0, 0, 0, 0, 0, 1, 0);
        v(10, 0, 1, 0, 0, 0, 0, 1, 0);
        v(10, 1, 1, 0, 0, 0, 0, 2, 1);
        v(10, 0, 0, 0, 0, 0, 0, 2, 0);
        v(10, 1, 0, 0, 0, 0, 0, 2, 0);
        v(10, 0, 0, 0, 0, 0, 0, 2, 0);
        for (int k = 0; k < 4; k++) begin
            v(2, 0, 1, 0, 0, 0, 0, 2, 0);
            v(2, 0, 0, 0, 0, 0, 0, 2, 0);
        end
        v(10, 1, 0, 0, 0, 0, 0, 2, 0);
        v(10, 0, 0, 0, 0, 0, 0, 2, 0);
        v(3, 0, 0, 1, 0, 0, 0, 2, 0);
        v(10, 0, 0, 0, 0, 0, 0, 2, 0);
        bus.tick_in = 1'b0;
        bus.btn_step = 1'b0;
        bus.sw_run = 1'b0;
        bus.halt = 1'b0;
        #12;
        check("reset cpu_en", bus.cpu_en, 1'b0);
        check("reset running", bus.running, 1'b0);
        check("reset cycle_count", bus.cycle_count, 4'd0);
        @(negedge clk_in);
        reset = 1'b0;
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));
        // reset landing in the middle of a pulse
        step("arm", 10, 0, 1, 0, 0, 0, 0, 2, 0);
        @(negedge clk_in);
        bus.tick_in = 1'b1;
        bus.btn_step = 1'b0;
        @(posedge clk_in);
        #1;
        check("pre-reset cpu_en", bus.cpu_en, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("async reset cpu_en", bus.cpu_en, 1'b0);
        check("async reset cycle_count", bus.cycle_count, 4'd0);
        check("async reset running", bus.running, 1'b0);
        @(negedge clk_in);
        reset = 1'b0;
        bus.tick_in = 1'b0;
        // a step pending at reset is lost
        step("pend", 10, 0, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk_in);
        reset = 1'b1;
        bus.btn_step = 1'b0;
        @(negedge clk_in);
        reset = 1'b0;
        step("lost", 10, 1, 0, 0, 0, 0, 0, 0, 0);
        step("lost_lo", 10, 0, 0, 0, 0, 0, 0, 0, 0);
        step("repress", 10, 0, 1, 0, 0, 0, 0, 0, 0);
        step("repulse", 10, 1, 1, 0, 0, 0, 0, 1, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hack_clock_control.md
# hack_clock_control

Run/step controller that sits directly downstream of the clock divider in the FPGA Hack computer. It turns the divider's slow square-wave tick into single-cycle CPU clock-enable pulses, so the whole computer stays on one clock. In run mode it issues one pulse per tick. In step mode it issues exactly one pulse per debounced push-button press. It also counts the CPU cycles it has issued.

## Interface
Parameters:
- DEBOUNCE, 500_000 — consecutive clk_in cycles an input must differ from its stable value before the stable value changes (10 ms at 50 MHz).
- CNT_W, 16 — width of cycle_count.

Ports:
- clk_in  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high; clears all state.
- tick_in  in  1  divided clock level from the clock divider, synchronous to clk_in.
- btn_step  in  1  raw step push-button, active-high, asynchronous.
- sw_run  in  1  raw run/step slide switch, 1 = run, asynchronous.
- halt  in  1  synchronous level from the CPU that blocks free-running.
- cpu_en  out  1  one-cycle CPU clock-enable pulse.
- running  out  1  high while the FSM is in RUN.
- cycle_count  out  CNT_W  number of cpu_en pulses issued, modulo 2^CNT_W.

## Operation
- **Input synchronisers:** btn_step and sw_run each pass through a 2-flop synchroniser. Synchroniser reset value is 0.
- **Debounce:** there is one counter per synchronised input.
  - While the synchronised value equals the stable value, the counter is held at 0.
  - While it differs, the counter increments.
  - When the counter reaches DEBOUNCE-1 and the values still differ, the stable value takes the synchronised value and the counter clears.
  - Stable values (btn_db, run_db) reset to 0.
- **Edge detect:**
  - tick_q registers tick_in; tick_rise = tick_in & ~tick_q.
  - btn_q registers btn_db; step_press = btn_db & ~btn_q.
  - tick_q and btn_q reset to 0.
- **FSM:**
  - IDLE (reset state):
    - run_db & ~halt -> RUN.
    - Otherwise step_press -> STEP_WAIT.
  - RUN:
    - halt | ~run_db -> IDLE.
    - Otherwise, on tick_rise, issue a pulse and stay in RUN.
  - STEP_WAIT:
    - On tick_rise, issue a pulse and go to IDLE.
    - halt is ignored, so stepping past a halt is allowed.
    - Further step_press events are ignored.
    - If run_db rises, finish the step, return to IDLE, then enter RUN.
- **Pulse gating:** in RUN, a tick_rise coinciding with halt=1 or run_db=0 produces no pulse (the exit takes precedence).
- **cycle_count:** increments by 1 on every clk_in edge where cpu_en=1. It wraps from 2^CNT_W-1 to 0.

## Timing
- Reset values: cpu_en=0, running=0, cycle_count=0, FSM=IDLE.
- reset asserted mid-pulse forces cpu_en=0 immediately (asynchronous). A pending step is discarded.
- cpu_en is a registered output.
  - If tick_in is first sampled high at edge k+1 (tick_q=0), cpu_en is high from edge k+1 to edge k+2.
  - The pulse is exactly 1 cycle wide.
- At most one pulse is issued per tick_in rising edge. A tick_in held high produces no further pulses.
- cycle_count updates at the edge that ends the pulse, i.e. it is visible 1 cycle after cpu_en.
- running is registered and equals (state==RUN). It changes at the same edge as the state transition.
- Input latency to run_db/btn_db: 2 synchroniser cycles + DEBOUNCE cycles of a stable level.
- Glitches shorter than DEBOUNCE cycles never change a stable value.
- tick_in rising while the FSM is in IDLE is dropped; it is not queued.

## Test plan
Bench parameters: DEBOUNCE=4, CNT_W=4. tick_in period is 20 cycles (high for 10 cycles).

- **Run mode:** reset, then sw_run=1. After debounce: running=1, then one 1-cycle cpu_en per tick_in rise. After 5 ticks, cycle_count=5. No pulse during tick_in high plateaus.
- **Step mode:** sw_run=0. Press btn_step for 10 cycles: exactly one cpu_en at the next tick rise, cycle_count=1. A second press during STEP_WAIT adds nothing.
- **Debounce:** btn_step toggled with 2-cycle glitches -> no pulse, FSM stays in IDLE. sw_run glitch of 3 cycles -> running stays 0.
- **Halt:** in RUN, assert halt -> running=0 at the next edge and no further pulses. A step press while halt=1 yields one pulse. Deasserting halt with sw_run=1 re-enters RUN.
- **Coincidence and wrap:** halt asserted in the same cycle as tick_rise in RUN -> no pulse. Run for 17 ticks -> cycle_count wraps 15 -> 0 and reads 1.
- **Reset mid-operation:** assert reset during cpu_en=1 -> cpu_en=0 and cycle_count=0 immediately. After release: FSM in IDLE, a pending step is lost, and a press is needed for the next pulse.
